// File: rtl/fetch_stage.sv
// fetch_stage: PC register, single-outstanding imem sequencer, IF/ID register.
// Optional macro FETCH_BUBBLE_CNT_EN adds a saturating bubble/flush counter.
module fetch_stage #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC = 32'hBFC00000,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR = 32'h00000013
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] pc_next,
  input  logic                  redirect,
  input  logic                  StallD,
  input  logic                  FlushD,
  output logic [DATA_WIDTH-1:0] PCF,
  output logic [DATA_WIDTH-1:0] PCPlus4F,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] InstrD,
  output logic [DATA_WIDTH-1:0] PCD,
  output logic [DATA_WIDTH-1:0] PCPlus4D,
  output logic                  validD
`ifdef FETCH_BUBBLE_CNT_EN
  ,
  output logic [31:0]           bubble_cnt
`endif
);

  typedef enum logic [1:0] {
    ISSUE,
    WAIT,
    HOLD,
    DROP
  } state_t;

  typedef struct packed {
    logic                  valid;
    logic [DATA_WIDTH-1:0] instr;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] pc4;
  } if_id_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] buf_q, buf_d;
  logic [DATA_WIDTH-1:0] pc_plus4;
  logic                  ld;
  logic [DATA_WIDTH-1:0] ld_instr;
  logic                  kill;
  if_id_t                ifid_q;

  assign pc_plus4  = pc_q + DATA_WIDTH'(4);
  assign kill      = FlushD | redirect;
  assign PCF       = pc_q;
  assign PCPlus4F  = pc_plus4;
  assign imem_addr = pc_q;
  assign validD    = ifid_q.valid;
  assign InstrD    = ifid_q.instr;
  assign PCD       = ifid_q.pc;
  assign PCPlus4D  = ifid_q.pc4;

  // State, PC and hold-buffer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ISSUE;
      pc_q    <= RESET_PC;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
    end
  end

  // Next-state, next-PC and load decision for the fetch sequencer.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    buf_d    = buf_q;
    ld       = 1'b0;
    ld_instr = buf_q;
    unique case (state_q)
      ISSUE: begin
        if (imem_gnt)
          state_d = redirect ? DROP : WAIT;
        if (redirect)
          pc_d = pc_next;
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (redirect) begin
            pc_d    = pc_next;
            state_d = ISSUE;
          end else if (!StallD) begin
            ld       = 1'b1;
            ld_instr = imem_rdata;
            pc_d     = pc_next;
            state_d  = ISSUE;
          end else begin
            buf_d   = imem_rdata;
            state_d = HOLD;
          end
        end else if (redirect) begin
          pc_d    = pc_next;
          state_d = DROP;
        end
      end
      HOLD: begin
        if (redirect) begin
          buf_d   = '0;
          pc_d    = pc_next;
          state_d = ISSUE;
        end else if (!StallD) begin
          ld       = 1'b1;
          ld_instr = buf_q;
          pc_d     = pc_next;
          state_d  = ISSUE;
        end
      end
      DROP: begin
        if (redirect)
          pc_d = pc_next;
        if (imem_rvalid)
          state_d = ISSUE;
      end
      default: state_d = ISSUE;
    endcase
  end

  // Request only goes out while no response is pending or buffered.
  always_comb begin
    imem_req = (state_q == ISSUE);
  end

  // IF/ID register: flush beats stall beats load; otherwise a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_q.valid <= 1'b0;
      ifid_q.instr <= NOP_INSTR;
      ifid_q.pc    <= '0;
      ifid_q.pc4   <= '0;
    end else if (kill) begin
      ifid_q.valid <= 1'b0;
      ifid_q.instr <= NOP_INSTR;
    end else if (StallD) begin
      ifid_q <= ifid_q;
    end else if (ld) begin
      ifid_q.valid <= 1'b1;
      ifid_q.instr <= ld_instr;
      ifid_q.pc    <= pc_q;
      ifid_q.pc4   <= pc_plus4;
    end else begin
      ifid_q.valid <= 1'b0;
      ifid_q.instr <= NOP_INSTR;
    end
  end

`ifdef FETCH_BUBBLE_CNT_EN
  logic bubble_hit;
  assign bubble_hit = kill | (!StallD & !ld);

  // Saturating count of cycles that write a bubble or flush into IF/ID.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      bubble_cnt <= '0;
    else if (bubble_hit && bubble_cnt != 32'hFFFFFFFF)
      bubble_cnt <= bubble_cnt + 32'd1;
  end
`endif

`ifdef SIM
  // Responses are never expected while a request is still being offered.
  always @(posedge clk) begin
    if (rst_n && state_q == ISSUE && imem_rvalid)
      $display("fetch_stage: stray imem_rvalid in ISSUE at %0t", $time);
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed plan checks plus randomized traffic against a
// transaction-level model of the fetch unit and a variable-latency memory.
module tb_fetch_stage;
  localparam logic [31:0] RST = 32'hBFC00000;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_nx;
  logic        redirect, StallD, FlushD;
  logic [31:0] PCF, PCPlus4F, imem_addr;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        validD;
`ifdef FETCH_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt;
`endif

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n),
    .pc_next(pc_nx), .redirect(redirect),
    .StallD(StallD), .FlushD(FlushD),
    .PCF(PCF), .PCPlus4F(PCPlus4F),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .InstrD(InstrD), .PCD(PCD),
    .PCPlus4D(PCPlus4D), .validD(validD)
`ifdef FETCH_BUBBLE_CNT_EN
    , .bubble_cnt(bubble_cnt)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: a fetch is either being offered, outstanding (live or doomed),
  // or sitting in a one-entry hold queue waiting for the stall to lift.
  logic [31:0] m_pc;
  bit          m_out, m_doom;
  logic [31:0] m_hq[$];
  bit          m_v;
  logic [31:0] m_instr, m_pcd, m_pc4d, m_bc;
  int          mem_wait;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_req();
    return !m_out && m_hq.size() == 0;
  endfunction

  task automatic m_reset();
    m_pc = RST; m_out = 0; m_doom = 0; m_hq.delete();
    m_v = 0; m_instr = NOP; m_pcd = 0; m_pc4d = 0; m_bc = 0;
    mem_wait = 0;
  endtask

  task automatic bump();
    if (m_bc != 32'hFFFFFFFF) m_bc = m_bc + 1;
  endtask

  task automatic m_step();
    logic [31:0] opc;
    logic [31:0] w;
    bit ld;
    opc = m_pc; ld = 0; w = '0;
    if (m_req()) begin
      if (imem_gnt) begin m_out = 1; m_doom = redirect; end
      if (redirect) m_pc = pc_nx;
    end else if (m_out && !m_doom) begin
      if (imem_rvalid) begin
        m_out = 0;
        if (redirect) m_pc = pc_nx;
        else if (!StallD) begin ld = 1; w = imem_rdata; m_pc = pc_nx; end
        else m_hq.push_back(imem_rdata);
      end else if (redirect) begin
        m_doom = 1; m_pc = pc_nx;
      end
    end else if (m_out) begin
      if (redirect) m_pc = pc_nx;
      if (imem_rvalid) begin m_out = 0; m_doom = 0; end
    end else begin
      if (redirect) begin m_hq.delete(); m_pc = pc_nx; end
      else if (!StallD) begin ld = 1; w = m_hq.pop_front(); m_pc = pc_nx; end
    end
    if (FlushD || redirect) begin
      m_v = 0; m_instr = NOP; bump();
    end else if (StallD) begin
    end else if (ld) begin
      m_v = 1; m_instr = w; m_pcd = opc; m_pc4d = opc + 32'd4;
    end else begin
      m_v = 0; m_instr = NOP; bump();
    end
  endtask

  task automatic compare_all();
    chk("PCF", PCF, m_pc);
    chk("PCPlus4F", PCPlus4F, m_pc + 32'd4);
    chk("imem_req", 32'(imem_req), 32'(m_req()));
    chk("imem_addr", imem_addr, m_pc);
    chk("validD", 32'(validD), 32'(m_v));
    chk("InstrD", InstrD, m_instr);
    chk("PCD", PCD, m_pcd);
    chk("PCPlus4D", PCPlus4D, m_pc4d);
`ifdef FETCH_BUBBLE_CNT_EN
    chk("bubble_cnt", bubble_cnt, m_bc);
`endif
  endtask

  task automatic cycle(input bit g, input bit rv, input logic [31:0] rd,
                       input bit rdr, input logic [31:0] pn,
                       input bit st, input bit fl);
    @(negedge clk);
    imem_gnt = g; imem_rvalid = rv; imem_rdata = rd;
    redirect = rdr; pc_nx = pn; StallD = st; FlushD = fl;
    compare_all();
    @(posedge clk);
    m_step();
    #1;
  endtask

  function automatic logic [31:0] p4();
    return m_pc + 32'd4;
  endfunction

  logic [31:0] bc0;

  initial begin
    rst_n = 0; pc_nx = 0; redirect = 0; StallD = 0; FlushD = 0;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_PCF", PCF, 32'hBFC00000);
    chk("rst_validD", 32'(validD), 32'd0);
    chk("rst_InstrD", InstrD, 32'h00000013);
    chk("rst_PCD", PCD, 32'd0);
    chk("rst_req", 32'(imem_req), 32'd1);
    @(negedge clk); rst_n = 1;

    chk("first_addr", imem_addr, 32'hBFC00000);
    cycle(1, 0, 0, 0, p4(), 0, 0);
    chk("wait_req", 32'(imem_req), 32'd0);
    cycle(0, 1, 32'h11111111, 0, p4(), 0, 0);
    chk("ld1_valid", 32'(validD), 32'd1);
    chk("ld1_PCD", PCD, 32'hBFC00000);
    chk("ld1_instr", InstrD, 32'h11111111);
    cycle(1, 0, 0, 0, p4(), 0, 0);
    cycle(0, 1, 32'h22222222, 0, p4(), 0, 0);
    chk("ld2_valid", 32'(validD), 32'd1);
    chk("ld2_PCD", PCD, 32'hBFC00004);
    chk("ld2_PCP4D", PCPlus4D, 32'hBFC00008);

    cycle(1, 0, 0, 0, p4(), 0, 0);
    cycle(0, 1, 32'h00A00093, 0, p4(), 1, 0);
    cycle(0, 0, 0, 0, p4(), 1, 0);
    cycle(0, 0, 0, 0, p4(), 1, 0);
    chk("stall_PCD", PCD, 32'hBFC00004);
    chk("stall_req", 32'(imem_req), 32'd0);
    chk("stall_PCF", PCF, 32'hBFC00008);
    cycle(0, 0, 0, 0, p4(), 0, 0);
    chk("rel_instr", InstrD, 32'h00A00093);
    chk("rel_PCD", PCD, 32'hBFC00008);
    chk("rel_addr", imem_addr, 32'hBFC0000C);
    chk("rel_req", 32'(imem_req), 32'd1);

    cycle(1, 0, 0, 0, p4(), 0, 0);
    cycle(0, 0, 0, 1, 32'hBFC00040, 0, 0);
    chk("drop_req", 32'(imem_req), 32'd0);
    cycle(0, 1, 32'hDEADBEEF, 0, p4(), 0, 0);
    chk("drop_valid", 32'(validD), 32'd0);
    chk("drop_addr", imem_addr, 32'hBFC00040);
    chk("drop_req2", 32'(imem_req), 32'd1);

    cycle(1, 0, 0, 0, p4(), 0, 0);
    cycle(0, 1, 32'h0BADF00D, 1, 32'hBFC00080, 0, 0);
    chk("rr_valid", 32'(validD), 32'd0);
    chk("rr_instr", InstrD, 32'h00000013);
    chk("rr_PCF", PCF, 32'hBFC00080);

    cycle(1, 0, 0, 0, p4(), 0, 0);
    cycle(0, 1, 32'h33333333, 0, p4(), 0, 0);
    chk("pre_fl_valid", 32'(validD), 32'd1);
    bc0 = m_bc;
    cycle(0, 0, 0, 0, p4(), 1, 1);
    chk("fl_valid", 32'(validD), 32'd0);
    chk("fl_instr", InstrD, 32'h00000013);
`ifdef FETCH_BUBBLE_CNT_EN
    chk("fl_bcnt", bubble_cnt, bc0 + 32'd1);
`endif

    cycle(1, 0, 0, 0, p4(), 0, 0);
    @(negedge clk);
    imem_gnt = 0; imem_rvalid = 0; redirect = 0; StallD = 0; FlushD = 0;
    rst_n = 0;
    #1;
    chk("arst_PCF", PCF, 32'hBFC00000);
    chk("arst_valid", 32'(validD), 32'd0);
    m_reset();
    @(negedge clk); rst_n = 1;
    chk("rst2_req", 32'(imem_req), 32'd1);
    cycle(1, 0, 0, 0, p4(), 0, 0);
    cycle(0, 1, 32'h44444444, 0, p4(), 0, 0);
    chk("rst2_PCD", PCD, 32'hBFC00000);

    for (int i = 0; i < 4000; i++) begin
      bit rq, g, rv, rdr, st, fl;
      logic [31:0] rd, pn;
      rq  = m_req();
      g   = $urandom_range(0, 99) < 60;
      rv  = (mem_wait == 1) || (rq && $urandom_range(0, 99) < 3);
      rd  = $urandom;
      rdr = $urandom_range(0, 99) < 10;
      pn  = rdr ? ($urandom & 32'hFFFFFFFC) : p4();
      if ($urandom_range(0, 199) == 0) pn = 32'hFFFFFFFC;
      st  = $urandom_range(0, 99) < 25;
      fl  = $urandom_range(0, 99) < 8;
      cycle(g, rv, rd, rdr, pn, st, fl);
      if (mem_wait > 0) mem_wait--;
      if (rq && g) mem_wait = $urandom_range(1, 3);
    end

    @(negedge clk);
    compare_all();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
